// File: rtl/lisnoc_router_output_arbiter_burst_if.sv
// Handshake bundle between per-VC output FIFOs, the output arbiter and the physical link.
// master = arbiter side, slave = FIFO/link environment side.
interface lisnoc_router_output_arbiter_burst_if #(
    parameter int flit_width = 34,
    parameter int vchannels  = 2
);
    logic [vchannels-1:0]            fifo_valid_i;
    logic [vchannels*flit_width-1:0] fifo_flit_i;
    logic [vchannels-1:0]            fifo_ready_o;
    logic [vchannels-1:0]            link_valid_o;
    logic [flit_width-1:0]           link_flit_o;
    logic [vchannels-1:0]            link_ready_i;

    modport master (
        input  fifo_valid_i, fifo_flit_i, link_ready_i,
        output fifo_ready_o, link_valid_o, link_flit_o
    );

    modport slave (
        output fifo_valid_i, fifo_flit_i, link_ready_i,
        input  fifo_ready_o, link_valid_o, link_flit_o
    );
endinterface

// File: rtl/lisnoc_router_output_arbiter_burst.sv
// LISNoC output-port arbiter: round-robin over VCs with a per-VC burst quota.
// Define LISNOC_ARB_PKT_LOCK_EN to lock the link to one VC from HEADER to LAST flit.
module lisnoc_router_output_arbiter_burst #(
    parameter  int flit_data_width = 32,
    parameter  int flit_type_width = 2,
    parameter  int vchannels       = 2,
    parameter  int max_burst       = 4,
    localparam int flit_width      = flit_data_width + flit_type_width,
    localparam int CW              = (vchannels > 1) ? $clog2(vchannels) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    lisnoc_router_output_arbiter_burst_if.master     arb,
    output logic [CW-1:0]                            active_channel_o
);

    localparam logic [7:0]    MAX_B     = 8'(max_burst);
    localparam logic [CW-1:0] LAST_VC   = CW'(vchannels - 1);

    logic [CW-1:0]         prev_q, prev_d;
    logic [7:0]            burst_q, burst_d;
    logic [vchannels-1:0]  serv_s;
    logic [vchannels-1:0]  grant_s;
    logic                  sel_valid_s;
    logic                  sel_cont_s;
    logic [CW-1:0]         sel_ch_s;
    logic [CW-1:0]         rr_idx_s;
    logic [CW-1:0]         flit_ch_s;
    logic [flit_width-1:0] sel_flit_s;
    logic                  lock_hold_s;
    logic [CW-1:0]         lock_ch_s;

`ifdef LISNOC_ARB_PKT_LOCK_EN
    localparam logic [1:0] TYPE_HEADER = 2'b01;
    localparam logic [1:0] TYPE_LAST   = 2'b10;

    logic                  locked_q, locked_d;
    logic [CW-1:0]         lock_ch_q, lock_ch_d;
    logic [1:0]            sel_type_s;

    assign lock_hold_s = locked_q;
    assign lock_ch_s   = lock_ch_q;
    assign sel_type_s  = sel_flit_s[flit_width-1 -: 2];
`else
    assign lock_hold_s = 1'b0;
    assign lock_ch_s   = '0;
`endif

    // Channel selection: packet lock, then burst continuation, then round-robin.
    always_comb begin
        serv_s      = arb.fifo_valid_i & arb.link_ready_i;
        sel_valid_s = 1'b0;
        sel_cont_s  = 1'b0;
        sel_ch_s    = prev_q;
        rr_idx_s    = prev_q;
        if (lock_hold_s) begin
            sel_valid_s = serv_s[lock_ch_s];
            sel_ch_s    = lock_ch_s;
        end else if ((burst_q != 8'd0) && (burst_q < MAX_B) && serv_s[prev_q]) begin
            sel_valid_s = 1'b1;
            sel_cont_s  = 1'b1;
        end else begin
            // prev_channel is visited last (i == vchannels wraps back onto it)
            for (int i = 1; i <= vchannels; i++) begin
                rr_idx_s = CW'((int'(prev_q) + i) % vchannels);
                if (!sel_valid_s && serv_s[rr_idx_s]) begin
                    sel_valid_s = 1'b1;
                    sel_ch_s    = rr_idx_s;
                end else begin
                    sel_valid_s = sel_valid_s;
                end
            end
        end
    end

    // Flit mux and one-hot grant vector; flit data never feeds the handshake.
    always_comb begin
        flit_ch_s  = sel_valid_s ? sel_ch_s : prev_q;
        sel_flit_s = arb.fifo_flit_i[flit_ch_s*flit_width +: flit_width];
        grant_s    = '0;
        if (sel_valid_s) begin
            grant_s[sel_ch_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    assign arb.link_valid_o = rst ? '0 : grant_s;
    assign arb.fifo_ready_o = rst ? '0 : grant_s;
    assign arb.link_flit_o  = rst ? '0 : sel_flit_s;
    assign active_channel_o = prev_q;

    // Next-state: burst bookkeeping and optional packet lock.
    always_comb begin
        prev_d  = prev_q;
        burst_d = burst_q;
        if (sel_valid_s) begin
            prev_d  = sel_ch_s;
            burst_d = sel_cont_s ? (burst_q + 8'd1) : 8'd1;
        end else begin
            burst_d = 8'd0;
        end
`ifdef LISNOC_ARB_PKT_LOCK_EN
        locked_d  = locked_q;
        lock_ch_d = lock_ch_q;
        if (locked_q) begin
            // the quota is frozen for the whole packet
            burst_d = burst_q;
            if (sel_valid_s && (sel_type_s == TYPE_LAST)) begin
                locked_d = 1'b0;
                burst_d  = 8'd0;
                prev_d   = lock_ch_q;
            end else begin
                locked_d = 1'b1;
            end
        end else if (sel_valid_s && (sel_type_s == TYPE_HEADER)) begin
            locked_d  = 1'b1;
            lock_ch_d = sel_ch_s;
        end else begin
            locked_d = 1'b0;
        end
`endif
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= LAST_VC;
            burst_q   <= 8'd0;
`ifdef LISNOC_ARB_PKT_LOCK_EN
            locked_q  <= 1'b0;
            lock_ch_q <= '0;
`endif
        end else begin
            prev_q    <= prev_d;
            burst_q   <= burst_d;
`ifdef LISNOC_ARB_PKT_LOCK_EN
            locked_q  <= locked_d;
            lock_ch_q <= lock_ch_d;
`endif
        end
    end

endmodule

// File: tb/tb_lisnoc_router_output_arbiter_burst.sv
// Directed bench for lisnoc_router_output_arbiter_burst (2 VCs, quota 4) with a grant model
// checked every cycle and literal grant sequences pinning the model.
module tb_lisnoc_router_output_arbiter_burst;
    localparam int VC  = 2;
    localparam int MB  = 4;
    localparam int FDW = 32;
    localparam int FTW = 2;
    localparam int FW  = FDW + FTW;

    localparam bit [1:0] T_PAY  = 2'b00;
    localparam bit [1:0] T_HDR  = 2'b01;
    localparam bit [1:0] T_LAST = 2'b10;
    localparam bit [1:0] T_SGL  = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [0:0] act;

    lisnoc_router_output_arbiter_burst_if #(.flit_width(FW), .vchannels(VC)) bus ();

    lisnoc_router_output_arbiter_burst #(
        .flit_data_width(FDW), .flit_type_width(FTW), .vchannels(VC), .max_burst(MB)
    ) dut (
        .clk(clk), .rst(rst), .arb(bus), .active_channel_o(act)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt     = 0;
    int glog[$];
    int exp_q[$];

    int m_prev, m_burst, m_locked, m_lock_ch;
    int n_prev, n_burst, n_locked, n_lock_ch;
    bit pend;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
        end
    endtask

    task automatic chk_seq(input string nm, input int s);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (s + i < glog.size()) check_int(nm, glog[s + i], exp_q[i]);
            else check_int({nm, "_missing"}, -9, exp_q[i]);
        end
    endtask

    task automatic drive(input bit [1:0] v, input bit [1:0] r, input bit [1:0] t0, input bit [1:0] t1);
        cnt++;
        bus.fifo_valid_i = v;
        bus.link_ready_i = r;
        bus.fifo_flit_i  = {t1, 32'hB000_0000 | 32'(cnt), t0, 32'hA000_0000 | 32'(cnt)};
    endtask

    task automatic cyc(input bit [1:0] v, input bit [1:0] r,
                       input bit [1:0] t0 = 2'b00, input bit [1:0] t1 = 2'b00);
        drive(v, r, t0, t1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Model: grant from the arbitration rules, checked on the falling edge, committed on the rising edge.
    initial begin : model
        bit [1:0]      serv;
        bit [1:0]      exp_oh;
        bit [1:0]      ty;
        logic [FW-1:0] ef;
        int            g;
        int            c;
        bit            cont;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_link_valid", 64'(bus.link_valid_o), 64'd0);
                check("rst_fifo_ready", 64'(bus.fifo_ready_o), 64'd0);
                check("rst_link_flit", 64'(bus.link_flit_o), 64'd0);
                check("rst_active", 64'(act), 64'(VC - 1));
                m_prev = VC - 1; m_burst = 0; m_locked = 0; m_lock_ch = 0;
                pend = 1'b0;
            end else begin
                serv = bus.fifo_valid_i & bus.link_ready_i;
                g = -1;
                cont = 1'b0;
                if (m_locked != 0) begin
                    if (serv[m_lock_ch]) g = m_lock_ch;
                end else if (m_burst > 0 && m_burst < MB && serv[m_prev]) begin
                    g = m_prev;
                    cont = 1'b1;
                end else begin
                    for (int k = 1; k <= VC; k++) begin
                        c = (m_prev + k) % VC;
                        if (g < 0 && serv[c]) g = c;
                    end
                end
                exp_oh = (g >= 0) ? (2'b01 << g) : 2'b00;
                check("link_valid", 64'(bus.link_valid_o), 64'(exp_oh));
                check("fifo_ready", 64'(bus.fifo_ready_o), 64'(exp_oh));
                check("active_channel", 64'(act), 64'(m_prev));
                ef = '0;
                if (g >= 0) begin
                    ef = bus.fifo_flit_i[g*FW +: FW];
                    check("link_flit", 64'(bus.link_flit_o), 64'(ef));
                end
                ty = ef[FW-1 -: 2];
                glog.push_back(g);
                n_prev = m_prev; n_burst = m_burst; n_locked = m_locked; n_lock_ch = m_lock_ch;
                if (g >= 0) begin
                    n_prev  = g;
                    n_burst = cont ? m_burst + 1 : 1;
                end else begin
                    n_burst = 0;
                end
`ifdef LISNOC_ARB_PKT_LOCK_EN
                if (m_locked != 0) begin
                    n_burst = m_burst;
                    if (g >= 0 && ty == T_LAST) begin
                        n_locked = 0;
                        n_burst  = 0;
                    end
                end else if (g >= 0 && ty == T_HDR) begin
                    n_locked  = 1;
                    n_lock_ch = g;
                end
`endif
                pend = 1'b1;
            end
            @(posedge clk);
            if (!rst && pend) begin
                m_prev = n_prev; m_burst = n_burst; m_locked = n_locked; m_lock_ch = n_lock_ch;
            end
        end
    end

    bit [3:0] vec [12] = '{4'b1111, 4'b1101, 4'b0111, 4'b1011, 4'b1110, 4'b0011,
                           4'b1111, 4'b1111, 4'b1010, 4'b0101, 4'b1111, 4'b1100};

    initial begin : stim
        int s;
        drive(2'b00, 2'b00, T_PAY, T_PAY);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // all serviceable: quota of 4 then rotate
        s = glog.size();
        repeat (10) cyc(2'b11, 2'b11);
        exp_q = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        chk_seq("rr_burst", s);

        // only VC1 serviceable: re-wins after each quota
        cyc(2'b00, 2'b00);
        s = glog.size();
        repeat (10) cyc(2'b10, 2'b11);
        exp_q = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        chk_seq("vc1_only", s);

        // VC0 mid-burst loses ready, VC1 takes over and keeps its full quota
        cyc(2'b00, 2'b00);
        s = glog.size();
        cyc(2'b01, 2'b11);
        cyc(2'b01, 2'b11);
        cyc(2'b11, 2'b10);
        repeat (4) cyc(2'b11, 2'b11);
        exp_q = '{0, 0, 1, 1, 1, 1, 0};
        chk_seq("ready_drop", s);

        // mixed valid/ready vectors, model-checked only
        for (int i = 0; i < 12; i++) cyc(vec[i][3:2], vec[i][1:0]);

        // asynchronous reset mid-burst
        cyc(2'b11, 2'b11);
        cyc(2'b11, 2'b11);
        #1 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(bus.link_valid_o), 64'd0);
        check("async_rst_ready", 64'(bus.fifo_ready_o), 64'd0);
        check("async_rst_flit", 64'(bus.link_flit_o), 64'd0);
        check("async_rst_active", 64'(act), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("post_rst_grant", 64'(bus.link_valid_o), 64'h1);
        s = glog.size();
        repeat (5) cyc(2'b11, 2'b11);
        exp_q = '{0, 0, 0, 0, 1};
        chk_seq("post_rst_seq", s);

`ifdef LISNOC_ARB_PKT_LOCK_EN
        // HEADER on VC0 locks the link through a 3-cycle valid gap
        do_reset();
        s = glog.size();
        cyc(2'b11, 2'b11, T_HDR, T_SGL);
        repeat (3) cyc(2'b10, 2'b11, T_PAY, T_SGL);
        cyc(2'b11, 2'b11, T_PAY, T_SGL);
        cyc(2'b11, 2'b11, T_LAST, T_SGL);
        cyc(2'b11, 2'b11, T_PAY, T_SGL);
        exp_q = '{0, -1, -1, -1, 0, 0, 1};
        chk_seq("pkt_lock_gap", s);

        // SINGLE flits on VC1 never lock
        do_reset();
        s = glog.size();
        cyc(2'b10, 2'b11, T_PAY, T_SGL);
        cyc(2'b10, 2'b11, T_PAY, T_SGL);
        cyc(2'b01, 2'b11, T_HDR, T_SGL);
        cyc(2'b11, 2'b11, T_PAY, T_SGL);
        cyc(2'b11, 2'b11, T_LAST, T_SGL);
        cyc(2'b11, 2'b11, T_PAY, T_SGL);
        exp_q = '{1, 1, 0, 0, 0, 1};
        chk_seq("single_no_lock", s);
`endif

        cyc(2'b00, 2'b00);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
